disp_scroller: RTL and testbench

//   Sequencer that feeds the 16-bit nibble value input of the 4x7 segment controller.

---
 rtl/disp_scroller.sv | 130 +++++++++++++
 tb/tb_disp_scroller.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/disp_scroller.sv
// Scrolls a 4-nibble window across a circular hex message buffer and drives the
// 16-bit value input of the 4x7 segment controller.
module disp_scroller #(
  parameter int unsigned MSG_LEN  = 16,
  parameter int unsigned TICK_DIV = 25000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic [3:0]  wr_addr,
  input  logic [3:0]  wr_data,
  input  logic        start,
  input  logic [4:0]  len_in,
  input  logic        stop,
  input  logic        hold,
  output logic [15:0] disp_val,
  output logic        busy,
  output logic        wrap,
  output logic        err
);

  localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned POS_W  = 4;
  localparam int unsigned LEN_W  = 5;
  localparam int unsigned VAL_W  = 16;
  localparam int unsigned DEPTH  = 16;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  state_t             state_q, state_d;
  logic [POS_W-1:0]   pos_q, pos_d;
  logic [TICK_W-1:0]  tick_q, tick_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [VAL_W-1:0]   disp_d;
  logic               busy_d, wrap_d, err_d;
  logic [3:0]         msg_q [DEPTH];
  logic               len_ok, tick_last;
  logic [LEN_W-1:0]   pos_inc;

  // Window of four consecutive nibbles starting at p, wrapping modulo l.
  function automatic logic [VAL_W-1:0] window(input logic [POS_W-1:0] p,
                                              input logic [LEN_W-1:0] l);
    logic [LEN_W-1:0] idx;
    logic [VAL_W-1:0] w;
    w = '0;
    for (int k = 0; k < 4; k++) begin
      idx = LEN_W'(p) + LEN_W'(k);
      if (idx >= l) idx = idx - l;
      w[VAL_W-1-4*k -: 4] = msg_q[idx[POS_W-1:0]];
    end
    return w;
  endfunction

  // Message buffer; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en && (LEN_W'(wr_addr) < LEN_W'(MSG_LEN))) msg_q[wr_addr] <= wr_data;
  end

  assign len_ok    = (len_in >= LEN_W'(4)) && (len_in <= LEN_W'(MSG_LEN));
  assign tick_last = (tick_q == TICK_W'(TICK_DIV - 1));
  assign pos_inc   = LEN_W'(pos_q) + LEN_W'(1);

  // Priority: stop, then start, then hold/scroll.
  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    tick_d  = tick_q;
    len_d   = len_q;
    disp_d  = disp_val;
    wrap_d  = 1'b0;
    err_d   = 1'b0;
    busy_d  = 1'b0;

    if (stop) begin
      state_d = IDLE;
      pos_d   = '0;
      tick_d  = '0;
      disp_d  = '0;
    end else if (start) begin
      if (len_ok) begin
        state_d = RUN;
        pos_d   = '0;
        tick_d  = '0;
        len_d   = len_in;
        disp_d  = window(POS_W'(0), len_in);
      end else begin
        err_d = 1'b1;
      end
    end else if (state_q != IDLE) begin
      if (hold) begin
        state_d = PAUSE;
      end else begin
        state_d = RUN;
        if (tick_last) begin
          tick_d = '0;
          pos_d  = (pos_inc == len_q) ? '0 : pos_inc[POS_W-1:0];
          disp_d = window(pos_d, len_q);
          wrap_d = (pos_inc == len_q);
        end else begin
          tick_d = tick_q + TICK_W'(1);
        end
      end
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      pos_q    <= '0;
      tick_q   <= '0;
      len_q    <= LEN_W'(4);
      disp_val <= '0;
      busy     <= 1'b0;
      wrap     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state_q  <= state_d;
      pos_q    <= pos_d;
      tick_q   <= tick_d;
      len_q    <= len_d;
      disp_val <= disp_d;
      busy     <= busy_d;
      wrap     <= wrap_d;
      err      <= err_d;
    end
  end

endmodule

// File: tb/tb_disp_scroller.sv
// Bench for disp_scroller: directed scenarios plus random traffic, all checked
// against a behavioural message/window model.
module tb_disp_scroller;

  localparam int unsigned MSG_LEN  = 16;
  localparam int unsigned TICK_DIV = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_addr = '0;
  logic [3:0]  wr_data = '0;
  logic        start = 1'b0;
  logic [4:0]  len_in = 5'd4;
  logic        stop = 1'b0;
  logic        hold = 1'b0;
  logic [15:0] disp_val;
  logic        busy, wrap, err;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit          m_run;
  int          m_pos, m_tick, m_len;
  logic [15:0] m_disp;
  logic        m_wrap, m_err;
  logic [3:0]  mbuf [16];

  disp_scroller #(.MSG_LEN(MSG_LEN), .TICK_DIV(TICK_DIV)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .len_in(len_in), .stop(stop), .hold(hold),
    .disp_val(disp_val), .busy(busy), .wrap(wrap), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] win(input int p, input int l);
    logic [15:0] w;
    for (int k = 0; k < 4; k++) w[15-4*k -: 4] = mbuf[(p + k) % l];
    return w;
  endfunction

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_pos = 0; m_tick = 0; m_len = 4;
    m_disp = 16'h0000; m_wrap = 1'b0; m_err = 1'b0;
  endtask

  // One clock edge of the specified behaviour, using the inputs now applied.
  task automatic model_update();
    m_wrap = 1'b0;
    m_err  = 1'b0;
    if (stop) begin
      m_run = 0; m_pos = 0; m_tick = 0; m_disp = 16'h0000;
    end else if (start) begin
      if (int'(len_in) >= 4 && int'(len_in) <= MSG_LEN) begin
        m_run = 1; m_pos = 0; m_tick = 0; m_len = int'(len_in);
        m_disp = win(0, m_len);
      end else begin
        m_err = 1'b1;
      end
    end else if (m_run && !hold) begin
      if (m_tick == TICK_DIV - 1) begin
        m_tick = 0;
        m_pos  = (m_pos + 1) % m_len;
        m_wrap = (m_pos == 0);
        m_disp = win(m_pos, m_len);
      end else begin
        m_tick++;
      end
    end
    if (wr_en && int'(wr_addr) < MSG_LEN) mbuf[wr_addr] = wr_data;
  endtask

  task automatic check_all();
    chk("disp_val", disp_val, m_disp);
    chk("busy", 16'(busy), 16'(m_run));
    chk("wrap", 16'(wrap), 16'(m_wrap));
    chk("err", 16'(err), 16'(m_err));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_update();
    #1;
    check_all();
  endtask

  task automatic wr(input logic [3:0] a, input logic [3:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    cycle();
    wr_en = 1'b0;
  endtask

  task automatic do_start(input logic [4:0] l);
    start = 1'b1; len_in = l;
    cycle();
    start = 1'b0;
  endtask

  initial begin
    logic [15:0] exp_w;
    logic [3:0]  msg [6];
    msg = '{4'h1, 4'hA, 4'hB, 4'h8, 4'hE, 4'h2};

    // Reset with no clock edge yet
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_disp", disp_val, 16'h0000);
    chk("rst_busy", 16'(busy), 16'h0);
    chk("rst_wrap", 16'(wrap), 16'h0);
    chk("rst_err", 16'(err), 16'h0);
    #2 rst_n = 1'b1;

    // Fill buffer with random content, then the directed message
    for (int i = 0; i < 16; i++) wr(4'(i), 4'($urandom));
    for (int i = 0; i < 6; i++) wr(4'(i), msg[i]);

    // Scroll across a 6-nibble message
    do_start(5'd6);
    chk("s2_first", disp_val, 16'h1AB8);
    chk("s2_busy", 16'(busy), 16'h1);
    repeat (4) cycle();
    chk("s2_step1", disp_val, 16'hAB8E);
    repeat (20) cycle();
    chk("s2_wrap_val", disp_val, 16'h1AB8);
    chk("s2_wrap", 16'(wrap), 16'h1);

    // Hold for 10 cycles mid-step delays the step by exactly 10
    repeat (2) cycle();
    hold = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycle();
      chk("s3_frozen", disp_val, 16'h1AB8);
      chk("s3_busy", 16'(busy), 16'h1);
    end
    hold = 1'b0;
    cycle();
    chk("s3_not_yet", disp_val, 16'h1AB8);
    cycle();
    chk("s3_step", disp_val, 16'hAB8E);

    // Write during RUN shows only on a later window load
    wr(4'd1, 4'hF);
    chk("s5_no_change", disp_val, 16'hAB8E);
    repeat (3) cycle();
    chk("s5_step", disp_val, 16'hB8E2);
    repeat (8) cycle();
    chk("s5_edit_shown", disp_val, 16'hE21F);

    // stop beats start
    stop = 1'b1; start = 1'b1; len_in = 5'd6;
    cycle();
    stop = 1'b0; start = 1'b0;
    chk("s5_coll_disp", disp_val, 16'h0000);
    chk("s5_coll_busy", 16'(busy), 16'h0);

    // Rejected starts
    do_start(5'd3);
    chk("s4_err3", 16'(err), 16'h1);
    chk("s4_idle3", disp_val, 16'h0000);
    cycle();
    chk("s4_err_clr", 16'(err), 16'h0);
    do_start(5'd17);
    chk("s4_err17", 16'(err), 16'h1);
    chk("s4_busy17", 16'(busy), 16'h0);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      wr_en   = ($urandom % 4) == 0;
      wr_addr = 4'($urandom);
      wr_data = 4'($urandom);
      hold    = ($urandom % 6) == 0;
      start   = ($urandom % 30) == 0;
      len_in  = 5'($urandom_range(2, 18));
      stop    = ($urandom % 80) == 0;
      cycle();
    end
    wr_en = 1'b0; hold = 1'b0; start = 1'b0; stop = 1'b0;

    // Asynchronous reset in the middle of RUN
    do_start(5'd7);
    repeat (5) cycle();
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    chk("s6_disp", disp_val, 16'h0000);
    chk("s6_busy", 16'(busy), 16'h0);
    chk("s6_wrap", 16'(wrap), 16'h0);
    chk("s6_err", 16'(err), 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_w = {mbuf[0], mbuf[1], mbuf[2], mbuf[3]};
    do_start(5'd4);
    chk("s6_len4", disp_val, exp_w);
    repeat (4) cycle();
    chk("s6_rot", disp_val, {exp_w[11:0], exp_w[15:12]});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
